// File: rtl/vga_timing_gen.sv
// vga_timing_gen: combined horizontal/vertical VGA timing generator.
//
// Both axes are driven from a single pixel-enable stream. Each axis runs its
// own FRONT_PORCH -> SYNC -> BACK_PORCH -> DISPLAY state machine. Timing and
// sync polarity are runtime-programmable. A new configuration is held in a
// pending set and only becomes active at the start of a visible frame.
//
// The internal "lead" timer drives the o_pre_* outputs. The main outputs are
// the same values delayed by PRELOAD enabled cycles. This lets a pixel source
// with a fetch latency of PRELOAD cycles stay aligned with o_de.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_en                  pixel enable; all state advances only when high
//   i_cfg_wr              captures i_h_*, i_v_*, i_*_pol into the pending set
//   i_h_* / i_v_*         timing fields (pixels / lines), 0 behaves as 1
//   i_hs_pol, i_vs_pol    sync polarity, 1 = active-high
//   o_cfg_pend            a pending configuration waits to be applied
//   o_hsync, o_vsync      sync outputs with polarity applied
//   o_de, o_x, o_y        display enable and per-axis active coordinates
//   o_line_start          first active pixel of each visible line
//   o_frame_start         pixel (0,0)
//   o_pre_de/x/y          lead-timer values, PRELOAD enabled cycles early
module vga_timing_gen #(
    parameter int CNT_W      = 12,
    parameter int PRELOAD    = 1,
    parameter int DEF_H_VIS  = 640,
    parameter int DEF_H_FP   = 16,
    parameter int DEF_H_SYNC = 96,
    parameter int DEF_H_BP   = 48,
    parameter int DEF_V_VIS  = 480,
    parameter int DEF_V_FP   = 10,
    parameter int DEF_V_SYNC = 2,
    parameter int DEF_V_BP   = 33,
    parameter bit DEF_HS_POL = 1'b0,
    parameter bit DEF_VS_POL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_cfg_wr,
    input  logic [CNT_W-1:0] i_h_vis,
    input  logic [CNT_W-1:0] i_h_fp,
    input  logic [CNT_W-1:0] i_h_sync,
    input  logic [CNT_W-1:0] i_h_bp,
    input  logic [CNT_W-1:0] i_v_vis,
    input  logic [CNT_W-1:0] i_v_fp,
    input  logic [CNT_W-1:0] i_v_sync,
    input  logic [CNT_W-1:0] i_v_bp,
    input  logic             i_hs_pol,
    input  logic             i_vs_pol,
    output logic             o_cfg_pend,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic             o_pre_de,
    output logic [CNT_W-1:0] o_pre_x,
    output logic [CNT_W-1:0] o_pre_y
);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_FP   = 2'd0,
        ST_SYNC = 2'd1,
        ST_BP   = 2'd2,
        ST_DISP = 2'd3
    } axis_state_t;

    typedef struct packed {
        cnt_t h_vis, h_fp, h_sync, h_bp;
        cnt_t v_vis, v_fp, v_sync, v_bp;
        logic hs_pol, vs_pol;
    } cfg_t;

    typedef struct packed {
        logic de;
        cnt_t x, y;
        logic hsync, vsync, line_start, frame_start;
    } tim_t;

    localparam cfg_t DEF_CFG = '{
        h_vis: cnt_t'(DEF_H_VIS), h_fp: cnt_t'(DEF_H_FP),
        h_sync: cnt_t'(DEF_H_SYNC), h_bp: cnt_t'(DEF_H_BP),
        v_vis: cnt_t'(DEF_V_VIS), v_fp: cnt_t'(DEF_V_FP),
        v_sync: cnt_t'(DEF_V_SYNC), v_bp: cnt_t'(DEF_V_BP),
        hs_pol: DEF_HS_POL, vs_pol: DEF_VS_POL
    };

    // Reset state is BACK_PORCH on both axes, so syncs sit at their inactive level.
    localparam tim_t IDLE = '{
        de: 1'b0, x: '0, y: '0,
        hsync: ~DEF_HS_POL, vsync: ~DEF_VS_POL,
        line_start: 1'b0, frame_start: 1'b0
    };

    function automatic axis_state_t next_state(input axis_state_t s);
        case (s)
            ST_FP:   return ST_SYNC;
            ST_SYNC: return ST_BP;
            ST_BP:   return ST_DISP;
            default: return ST_FP;
        endcase
    endfunction

    // Terminal count of the current state; a programmed 0 lasts one cycle.
    function automatic cnt_t last_cnt(input axis_state_t s, input cnt_t vis,
                                      input cnt_t fp, input cnt_t sync, input cnt_t bp);
        cnt_t len;
        case (s)
            ST_FP:   len = fp;
            ST_SYNC: len = sync;
            ST_BP:   len = bp;
            default: len = vis;
        endcase
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    function automatic tim_t decode(input axis_state_t hs, input cnt_t hc,
                                    input axis_state_t vs, input cnt_t vc,
                                    input logic hpol, input logic vpol);
        tim_t t;
        logic h_disp;
        logic v_disp;
        h_disp        = (hs == ST_DISP);
        v_disp        = (vs == ST_DISP);
        t.de          = h_disp && v_disp;
        t.x           = h_disp ? hc : '0;
        t.y           = v_disp ? vc : '0;
        t.hsync       = (hs == ST_SYNC) ~^ hpol;
        t.vsync       = (vs == ST_SYNC) ~^ vpol;
        t.line_start  = t.de && (hc == '0);
        t.frame_start = t.line_start && (vc == '0);
        return t;
    endfunction

    axis_state_t h_state_q, h_state_d, v_state_q, v_state_d;
    cnt_t        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    cfg_t        cfg_q, cfg_d, pend_cfg_q, pend_cfg_d;
    logic        pend_q, pend_d;
    tim_t        lead_q, lead_d;
    tim_t        main_tim;

    cnt_t h_last, v_last;
    logic h_end, v_end, line_end, apply;

    always_comb begin
        h_last   = last_cnt(h_state_q, cfg_q.h_vis, cfg_q.h_fp, cfg_q.h_sync, cfg_q.h_bp);
        v_last   = last_cnt(v_state_q, cfg_q.v_vis, cfg_q.v_fp, cfg_q.v_sync, cfg_q.v_bp);
        h_end    = (h_cnt_q == h_last);
        v_end    = (v_cnt_q == v_last);
        line_end = (h_state_q == ST_DISP) && h_end;
        // V BACK_PORCH -> DISPLAY always coincides with an H line end, so the
        // new frame starts at H FRONT_PORCH count 0 with the new config.
        apply    = line_end && (v_state_q == ST_BP) && v_end && pend_q;

        h_state_d  = h_state_q;
        h_cnt_d    = h_cnt_q;
        v_state_d  = v_state_q;
        v_cnt_d    = v_cnt_q;
        cfg_d      = cfg_q;
        pend_cfg_d = pend_cfg_q;
        pend_d     = pend_q;
        lead_d     = lead_q;

        if (i_en) begin
            if (h_end) begin
                h_state_d = next_state(h_state_q);
                h_cnt_d   = '0;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end

            if (line_end) begin
                if (v_end) begin
                    v_state_d = next_state(v_state_q);
                    v_cnt_d   = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end

            if (apply) begin
                cfg_d  = pend_cfg_q;
                pend_d = 1'b0;
            end

            // A write on the apply cycle lands after the old pending set moved out.
            if (i_cfg_wr) begin
                pend_cfg_d = '{
                    h_vis: i_h_vis, h_fp: i_h_fp, h_sync: i_h_sync, h_bp: i_h_bp,
                    v_vis: i_v_vis, v_fp: i_v_fp, v_sync: i_v_sync, v_bp: i_v_bp,
                    hs_pol: i_hs_pol, vs_pol: i_vs_pol
                };
                pend_d = 1'b1;
            end

            lead_d = decode(h_state_d, h_cnt_d, v_state_d, v_cnt_d,
                            cfg_d.hs_pol, cfg_d.vs_pol);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_state_q  <= ST_BP;
            h_cnt_q    <= '0;
            v_state_q  <= ST_BP;
            v_cnt_q    <= '0;
            cfg_q      <= DEF_CFG;
            pend_cfg_q <= '0;
            pend_q     <= 1'b0;
            lead_q     <= IDLE;
        end else begin
            h_state_q  <= h_state_d;
            h_cnt_q    <= h_cnt_d;
            v_state_q  <= v_state_d;
            v_cnt_q    <= v_cnt_d;
            cfg_q      <= cfg_d;
            pend_cfg_q <= pend_cfg_d;
            pend_q     <= pend_d;
            lead_q     <= lead_d;
        end
    end

    // Delay line from the lead timer to the main outputs.
    generate
        if (PRELOAD == 0) begin : g_no_pipe
            assign main_tim = lead_q;
        end else begin : g_pipe
            tim_t pipe_q [PRELOAD];
            tim_t pipe_d [PRELOAD];

            always_comb begin
                pipe_d = pipe_q;
                if (i_en) begin
                    pipe_d[0] = lead_q;
                    for (int i = 1; i < PRELOAD; i++) begin
                        pipe_d[i] = pipe_q[i-1];
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < PRELOAD; i++) begin
                        pipe_q[i] <= IDLE;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign main_tim = pipe_q[PRELOAD-1];
        end
    endgenerate

    assign o_cfg_pend    = pend_q;
    assign o_pre_de      = lead_q.de;
    assign o_pre_x       = lead_q.x;
    assign o_pre_y       = lead_q.y;
    assign o_de          = main_tim.de;
    assign o_x           = main_tim.x;
    assign o_y           = main_tim.y;
    assign o_hsync       = main_tim.hsync;
    assign o_vsync       = main_tim.vsync;
    assign o_line_start  = main_tim.line_start;
    assign o_frame_start = main_tim.frame_start;

endmodule
